// File: rtl/pico_qsys_gpio_ctrl.sv
// pico_qsys_gpio_ctrl: Avalon-MM GPIO with direction, set/clear aliases, synchronised edge capture and maskable irq
module pico_qsys_gpio_ctrl #(
  parameter int          WIDTH     = 8,
  parameter logic [31:0] RESET_OUT = 32'hAA,
  parameter logic [31:0] RESET_DIR = 32'hFF,
  parameter int          EDGE_MODE = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic [WIDTH-1:0] out_en,
  output logic             irq
);
  logic [WIDTH-1:0] data_out, dir, irqmask, edgecap, sync1, sync2, sync3;
  logic [WIDTH-1:0] wd, edge_det, clr, rd;
  logic             wr, unused_wd;
  always_comb begin
    wr       = chipselect & ~write_n;
    wd       = writedata[WIDTH-1:0];
    edge_det = EDGE_MODE == 0 ? sync2 & ~sync3 : EDGE_MODE == 1 ? ~sync2 & sync3 : sync2 ^ sync3;
    clr      = wr && address == 3'd3 ? wd : '0;
    rd       = address == 3'd0 ? sync2 :
               address == 3'd1 ? dir :
               address == 3'd2 ? irqmask :
               address == 3'd3 ? edgecap : '0;
  end
  assign readdata  = 32'(rd);
  assign out_port  = data_out;
  assign out_en    = dir;
  assign unused_wd = ^writedata;
  always_ff @(posedge clk) begin
    if (reset) begin
      data_out <= RESET_OUT[WIDTH-1:0];
      dir      <= RESET_DIR[WIDTH-1:0];
      irqmask  <= '0;
      edgecap  <= '0;
      sync1    <= '0;
      sync2    <= '0;
      sync3    <= '0;
      irq      <= 1'b0;
    end else begin
      sync1    <= in_port;
      sync2    <= sync1;
      sync3    <= sync2;
      data_out <= !wr ? data_out :
                  address == 3'd0 ? wd :
                  address == 3'd4 ? data_out | wd :
                  address == 3'd5 ? data_out & ~wd : data_out;
      if (wr && address == 3'd1) dir <= wd;
      if (wr && address == 3'd2) irqmask <= wd;
      edgecap  <= (edgecap & ~clr) | edge_det;
      irq      <= |(edgecap & irqmask);
    end
  end
endmodule

// File: tb/tb_pico_qsys_gpio_ctrl.sv
// tb_pico_qsys_gpio_ctrl: directed self-checking bench over rising, falling and any-edge instances
module tb_pico_qsys_gpio_ctrl;
  logic        clk = 1'b0, reset = 1'b1, chipselect = 1'b0, write_n = 1'b1;
  logic [2:0]  address = '0;
  logic [31:0] writedata = '0;
  logic [7:0]  in_port = '0;
  logic [31:0] rd0, rd1, rd2;
  logic [7:0]  op0, op1, op2, oe0, oe1, oe2;
  logic        irq0, irq1, irq2;
  int          n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;
  pico_qsys_gpio_ctrl #(.EDGE_MODE(0)) u0 (.clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd0), .in_port(in_port), .out_port(op0), .out_en(oe0), .irq(irq0));
  pico_qsys_gpio_ctrl #(.EDGE_MODE(1)) u1 (.clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd1), .in_port(in_port), .out_port(op1), .out_en(oe1), .irq(irq1));
  pico_qsys_gpio_ctrl #(.EDGE_MODE(2)) u2 (.clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd2), .in_port(in_port), .out_port(op2), .out_en(oe2), .irq(irq2));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    address = a;
    writedata = d;
    chipselect = 1'b1;
    write_n = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n = 1'b1;
  endtask
  task automatic sel(input logic [2:0] a);
    address = a;
    #1;
  endtask
  initial begin
    tick(2);
    check("rst_out", 32'(op0), 32'hAA);
    check("rst_en", 32'(oe0), 32'hFF);
    check("rst_irq", 32'(irq0), 32'h0);
    reset = 1'b0;
    tick();
    sel(3'd1); check("rst_dir_rd", rd0, 32'h0000_00FF);
    sel(3'd3); check("rst_cap_rd", rd0, 32'h0);
    sel(3'd2); check("rst_mask_rd", rd0, 32'h0);
    wr(3'd0, 32'h0000_000F); check("data_wr", 32'(op0), 32'h0F);
    wr(3'd4, 32'h0000_00F0); check("outset", 32'(op0), 32'hFF);
    wr(3'd5, 32'h0000_0081); check("outclr", 32'(op0), 32'h7E);
    sel(3'd4); check("outset_rd", rd0, 32'h0);
    sel(3'd5); check("outclr_rd", rd0, 32'h0);
    wr(3'd1, 32'hFFFF_FF00); sel(3'd1); check("dir_upper", rd0, 32'h0);
    check("dir_out_en", 32'(oe0), 32'h00);
    in_port = 8'h08;
    tick();
    sel(3'd0); check("sync_n1", rd0, 32'h0);
    tick();
    sel(3'd0); check("sync_n2", rd0, 32'h08);
    sel(3'd3); check("cap_n2", rd0, 32'h0);
    tick();
    sel(3'd3); check("cap_n3", rd0, 32'h08);
    check("cap_fall_ignores_rise", rd1, 32'h0);
    check("cap_any_rise", rd2, 32'h08);
    tick();
    check("irq_masked", 32'(irq0), 32'h0);
    wr(3'd2, 32'h0000_0008); check("irq_mask_lag", 32'(irq0), 32'h0);
    tick(); check("irq_set", 32'(irq0), 32'h1);
    wr(3'd3, 32'h0000_0008);
    sel(3'd3); check("w1c_clear", rd0, 32'h0);
    check("irq_hold", 32'(irq0), 32'h1);
    tick(); check("irq_drop", 32'(irq0), 32'h0);
    in_port = 8'h00;
    tick(3);
    sel(3'd3); check("cap_fall", rd1, 32'h08);
    check("cap_rise_ignores_fall", rd0, 32'h0);
    in_port = 8'h08;
    tick(2);
    wr(3'd3, 32'h0000_0008);
    sel(3'd3); check("set_wins", rd0, 32'h08);
    check("set_wins_any", rd2, 32'h08);
    check("w1c_no_edge", rd1, 32'h0);
    tick(); check("irq_after_set_wins", 32'(irq0), 32'h1);
    wr(3'd3, 32'h0000_00FF);
    sel(3'd3); check("any_clear", rd2, 32'h0);
    in_port = 8'h09;
    tick(3);
    sel(3'd3); check("any_tog1", rd2, 32'h01);
    check("rise_tog1", rd0, 32'h01);
    check("fall_tog1", rd1, 32'h0);
    wr(3'd3, 32'h0000_0001);
    sel(3'd3); check("any_w1c", rd2, 32'h0);
    in_port = 8'h08;
    tick(3);
    sel(3'd3); check("any_tog2", rd2, 32'h01);
    check("rise_tog2", rd0, 32'h0);
    check("fall_tog2", rd1, 32'h01);
    in_port = 8'h09;
    tick(3);
    sel(3'd3); check("cap_before_rst", rd0, 32'h01);
    in_port = 8'h00;
    reset = 1'b1;
    wr(3'd0, 32'h0000_0055);
    reset = 1'b0;
    check("rst_mid_out", 32'(op0), 32'hAA);
    check("rst_mid_en", 32'(oe0), 32'hFF);
    check("rst_mid_irq", 32'(irq0), 32'h0);
    sel(3'd3); check("rst_mid_cap", rd0, 32'h0);
    check("rst_mid_cap_fall", rd1, 32'h0);
    sel(3'd2); check("rst_mid_mask", rd0, 32'h0);
    wr(3'd6, 32'hFFFF_FFFF);
    check("rsvd_out", 32'(op0), 32'hAA);
    check("rsvd_en", 32'(oe0), 32'hFF);
    sel(3'd2); check("rsvd_mask", rd0, 32'h0);
    sel(3'd3); check("rsvd_cap", rd0, 32'h0);
    sel(3'd6); check("rsvd_rd6", rd0, 32'h0);
    sel(3'd7); check("rsvd_rd7", rd0, 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/pico_qsys_gpio_ctrl.md
Name: pico_qsys_gpio_ctrl

Overview:
Parametrised general-purpose I/O slave on the Avalon-MM system bus, successor to the single-register output PIO. Provides per-bit direction, an output data register with atomic set/clear aliases, a synchronised input path with edge capture, and a maskable interrupt. Sits on the Qsys interconnect beside the CPU's other peripherals. Pad tristate is instantiated at top level from out_port/out_en.

Parameters:
WIDTH, 8, number of GPIO bits (1..32).
RESET_OUT, 8'hAA, reset value of the output data register (WIDTH bits).
RESET_DIR, 8'hFF, reset value of the direction register (1 = output).
EDGE_MODE, 0, capture condition: 0 rising, 1 falling, 2 any edge.

Ports:
clk  in  1  system clock; all logic on posedge.
reset  in  1  synchronous, active-high reset.
address  in  3  register word index.
chipselect  in  1  slave select.
write_n  in  1  active-low write strobe (valid with chipselect).
writedata  in  32  write data; bits above WIDTH ignored.
readdata  out  32  read data, zero-extended above WIDTH.
in_port  in  WIDTH  asynchronous pad inputs.
out_port  out  WIDTH  output data register.
out_en  out  WIDTH  per-bit output enable (= direction register).
irq  out  1  level interrupt, active high.

Behaviour:
- Reset (reset=1 at posedge): data_out=RESET_OUT, dir=RESET_DIR, irqmask=0, edgecap=0, sync stages=0, irq=0. Reset applies mid-transaction; any write in the same cycle is discarded.
- Write occurs on a posedge with chipselect=1 and write_n=0; takes effect the following cycle. Zero wait states.
- Register map (address):
  0 DATA: read = synchronised input (sync2); write = data_out <= writedata[WIDTH-1:0].
  1 DIR: R/W; out_en = dir.
  2 IRQMASK: R/W.
  3 EDGECAP: read = capture bits; write = clear bits where writedata=1 (W1C).
  4 OUTSET: write = data_out <= data_out | wd; read 0.
  5 OUTCLR: write = data_out <= data_out & ~wd; read 0.
  6,7: reserved; read 0, writes ignored.
- readdata is combinational from address and current register state, no chipselect qualification; upper 32-WIDTH bits always 0.
- Input path: two-flop synchroniser (sync1, sync2) plus history flop sync3. Edge per bit: rising = sync2 & ~sync3; falling = ~sync2 & sync3; any = sync2 ^ sync3. Pin change reaches DATA read in 2 cycles, sets EDGECAP in 3.
- Edge capture is applied to all bits regardless of direction (output bits loop back through pad).
- Simultaneous edge detect and W1C on the same bit: set wins, bit stays 1.
- irq is registered: irq <= |(edgecap & irqmask); asserts 1 cycle after edgecap/mask condition, deasserts 1 cycle after clear.
- Out-of-range WIDTH upper writedata bits never alter state.

Test Plan:
1. Reset with WIDTH=8 -> out_port=0xAA, out_en=0xFF, irq=0; read addr 1 -> 0x000000FF, addr 3 -> 0.
2. Write addr0=0x0F, then addr4=0xF0, then addr5=0x81 -> out_port 0x0F, 0xFF, 0x7E on successive cycles; read addr4 -> 0.
3. EDGE_MODE=0, in_port bit3 0->1 at cycle N -> DATA read shows 0x08 from N+2, edgecap=0x08 at N+3; irqmask=0 so irq stays 0; write addr2=0x08 -> irq=1 one cycle later.
4. With edgecap=0x08, irq=1: write addr3=0x08 -> edgecap=0, irq falls next cycle; repeat with a new bit3 rising edge landing on the same cycle as the W1C -> edgecap stays 0x08.
5. EDGE_MODE=2, toggle bit0 twice with W1C between -> capture set each toggle; EDGE_MODE=1 ignores 0->1.
6. Assert reset during a write to addr0=0x55 with edgecap nonzero -> out_port=0xAA, edgecap=0, write lost; write addr6=0xFFFFFFFF -> no state change, read addr6=0.
